// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC, runs the imem req/ready handshake and applies redirects from ID.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [1:0]  pc_source,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] jr_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic [5:0]  opcode,
    output logic [5:0]  func
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      r_state, w_state_next;
    logic [31:0] r_pc, w_pc_next;
    logic [31:0] r_ifid_instr, w_ifid_instr_next;
    logic [31:0] r_ifid_pc4, w_ifid_pc4_next;
    logic        r_ifid_valid, w_ifid_valid_next;
    logic [31:0] r_hold_instr, w_hold_instr_next;
    logic [31:0] r_pending_pc, w_pending_pc_next;

    logic        w_redirect;
    logic [31:0] w_target;
    logic [31:0] w_pc4;

    assign w_pc4 = r_pc + 32'd4;

    // Stall has priority: a redirect is only acted on when ID can advance.
    assign w_redirect = r_ifid_valid & ~stall &
                        ((pc_source == 2'b10) | (pc_source == 2'b11) |
                         ((pc_source == 2'b01) & branch_taken));

    always_comb begin
        w_target = jr_target;
        case (pc_source)
            2'b01:   w_target = branch_target;
            2'b10:   w_target = {r_ifid_pc4[31:28], r_ifid_instr[25:0], 2'b00};
            default: w_target = jr_target;
        endcase
    end

    always_comb begin
        w_state_next      = r_state;
        w_pc_next         = r_pc;
        w_ifid_instr_next = r_ifid_instr;
        w_ifid_pc4_next   = r_ifid_pc4;
        w_ifid_valid_next = r_ifid_valid;
        w_hold_instr_next = r_hold_instr;
        w_pending_pc_next = r_pending_pc;

        case (r_state)
            S_FETCH: begin
                if (w_redirect) begin
                    w_ifid_instr_next = 32'd0;
                    w_ifid_valid_next = 1'b0;
                    if (imem_ready) begin
                        w_pc_next = w_target;
                    end else begin
                        // Request already issued; it must complete before we move on.
                        w_pending_pc_next = w_target;
                        w_state_next      = S_DRAIN;
                    end
                end else if (imem_ready && !stall) begin
                    w_ifid_instr_next = imem_rdata;
                    w_ifid_pc4_next   = w_pc4;
                    w_ifid_valid_next = 1'b1;
                    w_pc_next         = w_pc4;
                end else if (imem_ready) begin
                    w_hold_instr_next = imem_rdata;
                    w_state_next      = S_HOLD;
                end else if (!stall) begin
                    w_ifid_instr_next = 32'd0;
                    w_ifid_valid_next = 1'b0;
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    w_state_next = S_FETCH;
                    if (w_redirect) begin
                        w_pc_next         = w_target;
                        w_ifid_instr_next = 32'd0;
                        w_ifid_valid_next = 1'b0;
                    end else begin
                        w_ifid_instr_next = r_hold_instr;
                        w_ifid_pc4_next   = w_pc4;
                        w_ifid_valid_next = 1'b1;
                        w_pc_next         = w_pc4;
                    end
                end
            end
            S_DRAIN: begin
                if (w_redirect) begin
                    w_pending_pc_next = w_target;
                end
                if (imem_ready) begin
                    w_pc_next    = w_redirect ? w_target : r_pending_pc;
                    w_state_next = S_FETCH;
                end
                if (!stall) begin
                    w_ifid_instr_next = 32'd0;
                    w_ifid_valid_next = 1'b0;
                end
            end
            default: begin
                w_state_next = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_FETCH;
            r_pc         <= RESET_PC;
            r_ifid_instr <= 32'd0;
            r_ifid_pc4   <= 32'd0;
            r_ifid_valid <= 1'b0;
            r_hold_instr <= 32'd0;
            r_pending_pc <= 32'd0;
        end else begin
            r_state      <= w_state_next;
            r_pc         <= w_pc_next;
            r_ifid_instr <= w_ifid_instr_next;
            r_ifid_pc4   <= w_ifid_pc4_next;
            r_ifid_valid <= w_ifid_valid_next;
            r_hold_instr <= w_hold_instr_next;
            r_pending_pc <= w_pending_pc_next;
        end
    end

    // Gating with rst keeps the request low while reset is held, high right after.
    assign imem_req   = (r_state != S_HOLD) & ~rst;
    assign imem_addr  = r_pc;
    assign ifid_instr = r_ifid_instr;
    assign ifid_pc4   = r_ifid_pc4;
    assign ifid_valid = r_ifid_valid;
    assign opcode     = r_ifid_instr[31:26];
    assign func       = r_ifid_instr[5:0];

endmodule
